// File: rtl/stack_sequencer.sv
// Stack push/pop sequencer for 16-bit register pairs: drives the register file,
// the SP pair and a byte-wide memory, popping through WZ before copying to the pair.
package stack_sequencer_pkg;
    typedef enum logic [3:0] {
        REG_B = 4'd0, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A, REG_F, REG_W, REG_Z
    } register_n_t;

    typedef enum logic [2:0] {
        RR_BC = 3'd0, RR_DE, RR_HL, RR_AF, RR_SP, RR_PC, RR_WZ
    } register_nn_t;

    typedef enum logic [2:0] {
        COPY_NONE = 3'd0, COPY_WZ_TO_BC, COPY_WZ_TO_DE, COPY_WZ_TO_HL,
        COPY_WZ_TO_AF, COPY_WZ_TO_SP, COPY_WZ_TO_PC
    } copy_wz_to_rr_op_t;
endpackage

module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int CHECK_PAIR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_pop,
    input  copy_wz_to_rr_op_t pair,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              read_r,
    output register_n_t       read_reg_r,
    input  logic [7:0]        data_out_r,
    output logic              read_rr,
    output register_nn_t      read_reg_rr,
    input  logic [15:0]       data_out_rr,
    output logic              write_r,
    output register_n_t       write_reg_r,
    output logic [7:0]        data_in_r,
    output logic              write_rr,
    output register_nn_t      write_reg_rr,
    output logic [15:0]       data_in_rr,
    output copy_wz_to_rr_op_t copy_wz_to_rr_op,
    output logic [15:0]       mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_W, POP_COPY
    } state_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              err;
        logic              read_r;
        register_n_t       read_reg_r;
        logic              read_rr;
        register_nn_t      read_reg_rr;
        logic              write_r;
        register_n_t       write_reg_r;
        logic              write_rr;
        register_nn_t      write_reg_rr;
        copy_wz_to_rr_op_t copy_op;
        logic              mem_we;
        logic              mem_re;
    } ctl_t;

    state_t            state_q, state_d;
    copy_wz_to_rr_op_t pair_q, pair_d;
    ctl_t              ctl_q, ctl_d;
    logic              pair_ok;
    logic [15:0]       sp_dec, sp_inc;

    function automatic register_n_t hi_reg(input copy_wz_to_rr_op_t p);
        case (p)
            COPY_WZ_TO_DE: hi_reg = REG_D;
            COPY_WZ_TO_HL: hi_reg = REG_H;
            COPY_WZ_TO_AF: hi_reg = REG_A;
            default:       hi_reg = REG_B;
        endcase
    endfunction

    function automatic register_n_t lo_reg(input copy_wz_to_rr_op_t p);
        case (p)
            COPY_WZ_TO_DE: lo_reg = REG_E;
            COPY_WZ_TO_HL: lo_reg = REG_L;
            COPY_WZ_TO_AF: lo_reg = REG_F;
            default:       lo_reg = REG_C;
        endcase
    endfunction

    assign pair_ok = pair inside {COPY_WZ_TO_BC, COPY_WZ_TO_DE, COPY_WZ_TO_HL, COPY_WZ_TO_AF};
    assign sp_dec  = data_out_rr - 16'd1;
    assign sp_inc  = data_out_rr + 16'd1;

    // Control outputs are decoded from the next state so they leave a flop
    // aligned with the state they belong to.
    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        ctl_d   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (CHECK_PAIR != 0 && !pair_ok) begin
                        ctl_d.err = 1'b1;
                    end else begin
                        pair_d  = pair;
                        state_d = op_pop ? POP_LO : PUSH_HI;
                    end
                end
            end
            PUSH_HI:  state_d = PUSH_LO;
            PUSH_LO:  state_d = IDLE;
            POP_LO:   state_d = POP_HI;
            POP_HI:   state_d = POP_W;
            POP_W:    state_d = POP_COPY;
            POP_COPY: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        ctl_d.busy    = (state_d != IDLE);
        ctl_d.read_rr = ctl_d.busy;
        if (ctl_d.busy) begin
            ctl_d.read_reg_rr = RR_SP;
        end
        case (state_d)
            PUSH_HI, PUSH_LO: begin
                ctl_d.read_r       = 1'b1;
                ctl_d.read_reg_r   = (state_d == PUSH_HI) ? hi_reg(pair_d) : lo_reg(pair_d);
                ctl_d.mem_we       = 1'b1;
                ctl_d.write_rr     = 1'b1;
                ctl_d.write_reg_rr = RR_SP;
                ctl_d.done         = (state_d == PUSH_LO);
            end
            POP_LO, POP_HI: begin
                ctl_d.mem_re       = 1'b1;
                ctl_d.write_rr     = 1'b1;
                ctl_d.write_reg_rr = RR_SP;
                ctl_d.write_r      = (state_d == POP_HI);
                if (state_d == POP_HI) begin
                    ctl_d.write_reg_r = REG_Z;
                end
            end
            POP_W: begin
                ctl_d.write_r     = 1'b1;
                ctl_d.write_reg_r = REG_W;
            end
            POP_COPY: begin
                ctl_d.copy_op      = pair_d;
                ctl_d.write_reg_rr = RR_PC;
                ctl_d.done         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pair_q  <= COPY_NONE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            ctl_q   <= ctl_d;
        end
    end

    // Address and data follow the live SP read, so they stay combinational.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        data_in_r  = '0;
        data_in_rr = '0;
        case (state_q)
            PUSH_HI, PUSH_LO: begin
                mem_addr   = sp_dec;
                mem_wdata  = data_out_r;
                data_in_rr = sp_dec;
            end
            POP_LO: begin
                mem_addr   = data_out_rr;
                data_in_rr = sp_inc;
            end
            POP_HI: begin
                mem_addr   = data_out_rr;
                data_in_rr = sp_inc;
                data_in_r  = mem_rdata;
            end
            POP_W:   data_in_r = mem_rdata;
            default: ;
        endcase
    end

    assign busy             = ctl_q.busy;
    assign done             = ctl_q.done;
    assign err              = ctl_q.err;
    assign read_r           = ctl_q.read_r;
    assign read_reg_r       = ctl_q.read_reg_r;
    assign read_rr          = ctl_q.read_rr;
    assign read_reg_rr      = ctl_q.read_reg_rr;
    assign write_r          = ctl_q.write_r;
    assign write_reg_r      = ctl_q.write_reg_r;
    assign write_rr         = ctl_q.write_rr;
    assign write_reg_rr     = ctl_q.write_reg_rr;
    assign copy_wz_to_rr_op = ctl_q.copy_op;
    assign mem_we           = ctl_q.mem_we;
    assign mem_re           = ctl_q.mem_re;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a small register file and memory surround
// the DUT and each task checks its own hand-computed results.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, op_pop;
    copy_wz_to_rr_op_t pair;
    logic              busy, done, err, read_r, read_rr, write_r, write_rr, mem_we, mem_re;
    register_n_t       read_reg_r, write_reg_r;
    register_nn_t      read_reg_rr, write_reg_rr;
    copy_wz_to_rr_op_t copy_wz_to_rr_op;
    logic [7:0]        data_out_r, data_in_r, mem_wdata, mem_rdata;
    logic [15:0]       data_out_rr, data_in_rr, mem_addr;

    logic [7:0]  rf [0:15];
    logic [7:0]  mem [0:65535];
    logic [15:0] sp_reg, pc_reg;
    logic [2:0]  ld_kind;
    logic [15:0] ld_addr, ld_data;
    int          we_cnt, wr_cnt, wrr_cnt, copy_cnt;
    int          n_cmp, n_fail;

    always #5 clk = ~clk;

    stack_sequencer #(.CHECK_PAIR(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op_pop(op_pop), .pair(pair),
        .busy(busy), .done(done), .err(err),
        .read_r(read_r), .read_reg_r(read_reg_r), .data_out_r(data_out_r),
        .read_rr(read_rr), .read_reg_rr(read_reg_rr), .data_out_rr(data_out_rr),
        .write_r(write_r), .write_reg_r(write_reg_r), .data_in_r(data_in_r),
        .write_rr(write_rr), .write_reg_rr(write_reg_rr), .data_in_rr(data_in_rr),
        .copy_wz_to_rr_op(copy_wz_to_rr_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // Register file reads are combinational, as the sequencer expects.
    always_comb data_out_r = rf[read_reg_r];
    always_comb begin
        case (read_reg_rr)
            RR_BC:   data_out_rr = {rf[REG_B], rf[REG_C]};
            RR_DE:   data_out_rr = {rf[REG_D], rf[REG_E]};
            RR_HL:   data_out_rr = {rf[REG_H], rf[REG_L]};
            RR_AF:   data_out_rr = {rf[REG_A], rf[REG_F]};
            RR_SP:   data_out_rr = sp_reg;
            RR_PC:   data_out_rr = pc_reg;
            RR_WZ:   data_out_rr = {rf[REG_W], rf[REG_Z]};
            default: data_out_rr = 16'h0000;
        endcase
    end

    // Environment: register file, SP/PC, memory, WZ copy and the bench preload port.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (write_r) begin
            rf[write_reg_r] <= data_in_r;
            wr_cnt <= wr_cnt + 1;
        end
        if (write_rr) begin
            case (write_reg_rr)
                RR_BC: begin rf[REG_B] <= data_in_rr[15:8]; rf[REG_C] <= data_in_rr[7:0]; end
                RR_DE: begin rf[REG_D] <= data_in_rr[15:8]; rf[REG_E] <= data_in_rr[7:0]; end
                RR_HL: begin rf[REG_H] <= data_in_rr[15:8]; rf[REG_L] <= data_in_rr[7:0]; end
                RR_AF: begin rf[REG_A] <= data_in_rr[15:8]; rf[REG_F] <= data_in_rr[7:0]; end
                RR_SP: sp_reg <= data_in_rr;
                RR_PC: pc_reg <= data_in_rr;
                default: ;
            endcase
            wrr_cnt <= wrr_cnt + 1;
        end
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        case (copy_wz_to_rr_op)
            COPY_WZ_TO_BC: begin rf[REG_B] <= rf[REG_W]; rf[REG_C] <= rf[REG_Z]; end
            COPY_WZ_TO_DE: begin rf[REG_D] <= rf[REG_W]; rf[REG_E] <= rf[REG_Z]; end
            COPY_WZ_TO_HL: begin rf[REG_H] <= rf[REG_W]; rf[REG_L] <= rf[REG_Z]; end
            COPY_WZ_TO_AF: begin rf[REG_A] <= rf[REG_W]; rf[REG_F] <= {rf[REG_Z][7:4], rf[REG_F][3:0]}; end
            default: ;
        endcase
        if (copy_wz_to_rr_op != COPY_NONE) copy_cnt <= copy_cnt + 1;
        case (ld_kind)
            3'd1: rf[ld_addr[3:0]] <= ld_data[7:0];
            3'd2: sp_reg <= ld_data;
            3'd3: mem[ld_addr] <= ld_data[7:0];
            3'd4: begin we_cnt <= 0; wr_cnt <= 0; wrr_cnt <= 0; copy_cnt <= 0; end
            default: ;
        endcase
    end

    task automatic poke(input logic [2:0] kind, input logic [15:0] addr, input logic [15:0] data);
        ld_kind = kind; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_kind = 3'd0;
    endtask

    // Issues one request, returns cycles from acceptance to done, ends in the IDLE cycle.
    task automatic do_op(input logic pop, input copy_wz_to_rr_op_t p, output int lat);
        start = 1'b1; op_pop = pop; pair = p;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err); end
        n_cmp++; if ({read_r, read_rr, write_r, write_rr, mem_we, mem_re} !== 6'b0) begin
            n_fail++; $display("FAIL reset_enables: got %b want 000000", {read_r, read_rr, write_r, write_rr, mem_we, mem_re}); end
        n_cmp++; if (copy_wz_to_rr_op !== COPY_NONE) begin n_fail++; $display("FAIL reset_copy: got %0d want 0", copy_wz_to_rr_op); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_push;
        int lat;
        poke(3'd1, 16'(REG_B), 16'h12); poke(3'd1, 16'(REG_C), 16'h34); poke(3'd2, 16'h0, 16'hFFFE);
        do_op(1'b0, COPY_WZ_TO_BC, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL push_latency: got %0d want 2", lat); end
        n_cmp++; if (mem[16'hFFFD] !== 8'h12) begin n_fail++; $display("FAIL push_hi_byte: got %h want 12", mem[16'hFFFD]); end
        n_cmp++; if (mem[16'hFFFC] !== 8'h34) begin n_fail++; $display("FAIL push_lo_byte: got %h want 34", mem[16'hFFFC]); end
        n_cmp++; if (sp_reg !== 16'hFFFC) begin n_fail++; $display("FAIL push_sp: got %h want FFFC", sp_reg); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL push_idle: got %0h want 0", busy); end
    endtask

    task automatic test_pop;
        int lat;
        poke(3'd2, 16'h0, 16'hFFFC);
        do_op(1'b1, COPY_WZ_TO_DE, lat);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL pop_latency: got %0d want 4", lat); end
        n_cmp++; if (rf[REG_D] !== 8'h12) begin n_fail++; $display("FAIL pop_d: got %h want 12", rf[REG_D]); end
        n_cmp++; if (rf[REG_E] !== 8'h34) begin n_fail++; $display("FAIL pop_e: got %h want 34", rf[REG_E]); end
        n_cmp++; if (sp_reg !== 16'hFFFE) begin n_fail++; $display("FAIL pop_sp: got %h want FFFE", sp_reg); end
    endtask

    task automatic test_wrap;
        int lat;
        poke(3'd1, 16'(REG_H), 16'hAB); poke(3'd1, 16'(REG_L), 16'hCD); poke(3'd2, 16'h0, 16'h0000);
        do_op(1'b0, COPY_WZ_TO_HL, lat);
        n_cmp++; if (mem[16'hFFFF] !== 8'hAB) begin n_fail++; $display("FAIL wrap_push_hi: got %h want AB", mem[16'hFFFF]); end
        n_cmp++; if (mem[16'hFFFE] !== 8'hCD) begin n_fail++; $display("FAIL wrap_push_lo: got %h want CD", mem[16'hFFFE]); end
        n_cmp++; if (sp_reg !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_push_sp: got %h want FFFE", sp_reg); end
        poke(3'd3, 16'h0000, 16'h77); poke(3'd2, 16'h0, 16'hFFFF);
        do_op(1'b1, COPY_WZ_TO_BC, lat);
        n_cmp++; if (sp_reg !== 16'h0001) begin n_fail++; $display("FAIL wrap_pop_sp: got %h want 0001", sp_reg); end
        n_cmp++; if ({rf[REG_B], rf[REG_C]} !== 16'h77AB) begin
            n_fail++; $display("FAIL wrap_pop_bc: got %h want 77AB", {rf[REG_B], rf[REG_C]}); end
    endtask

    task automatic test_pop_af;
        int lat;
        poke(3'd1, 16'(REG_F), 16'h0A); poke(3'd3, 16'h1000, 16'hFF); poke(3'd3, 16'h1001, 16'h5A);
        poke(3'd2, 16'h0, 16'h1000);
        do_op(1'b1, COPY_WZ_TO_AF, lat);
        n_cmp++; if (rf[REG_A] !== 8'h5A) begin n_fail++; $display("FAIL af_a: got %h want 5A", rf[REG_A]); end
        n_cmp++; if (rf[REG_F] !== 8'hFA) begin n_fail++; $display("FAIL af_f: got %h want FA", rf[REG_F]); end
        n_cmp++; if (sp_reg !== 16'h1002) begin n_fail++; $display("FAIL af_sp: got %h want 1002", sp_reg); end
    endtask

    task automatic test_bad_pair;
        poke(3'd4, 16'h0, 16'h0);
        start = 1'b1; op_pop = 1'b0; pair = COPY_WZ_TO_SP;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_pair_err: got %0h want 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_pair_busy: got %0h want 0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_pair_pulse: got %0h want 0", err); end
        n_cmp++; if (we_cnt + wrr_cnt + wr_cnt !== 0) begin
            n_fail++; $display("FAIL bad_pair_writes: got %0d want 0", we_cnt + wrr_cnt + wr_cnt); end
    endtask

    task automatic test_busy_ignored;
        poke(3'd1, 16'(REG_B), 16'hA1); poke(3'd1, 16'(REG_C), 16'hB2); poke(3'd2, 16'h0, 16'h4000);
        start = 1'b1; op_pop = 1'b0; pair = COPY_WZ_TO_BC;
        @(posedge clk); #1;
        op_pop = 1'b1; pair = COPY_WZ_TO_DE;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_ign_done: got %0h want 1", done); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ign_idle: got %0h want 0", busy); end
        n_cmp++; if (sp_reg !== 16'h3FFE) begin n_fail++; $display("FAIL busy_ign_sp: got %h want 3FFE", sp_reg); end
        n_cmp++; if (mem[16'h3FFF] !== 8'hA1) begin n_fail++; $display("FAIL busy_ign_mem: got %h want A1", mem[16'h3FFF]); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2;
        poke(3'd1, 16'(REG_D), 16'h9A); poke(3'd1, 16'(REG_E), 16'hBC); poke(3'd2, 16'h0, 16'h2000);
        do_op(1'b0, COPY_WZ_TO_DE, lat1);
        do_op(1'b1, COPY_WZ_TO_HL, lat2);
        n_cmp++; if (lat1 !== 2) begin n_fail++; $display("FAIL b2b_push_lat: got %0d want 2", lat1); end
        n_cmp++; if (lat2 !== 4) begin n_fail++; $display("FAIL b2b_pop_lat: got %0d want 4", lat2); end
        n_cmp++; if ({rf[REG_H], rf[REG_L]} !== 16'h9ABC) begin
            n_fail++; $display("FAIL b2b_hl: got %h want 9ABC", {rf[REG_H], rf[REG_L]}); end
        n_cmp++; if (sp_reg !== 16'h2000) begin n_fail++; $display("FAIL b2b_sp: got %h want 2000", sp_reg); end
    endtask

    task automatic test_reset_mid;
        poke(3'd2, 16'h0, 16'h3000); poke(3'd3, 16'h3000, 16'h11); poke(3'd3, 16'h3001, 16'h22);
        poke(3'd1, 16'(REG_W), 16'h00); poke(3'd1, 16'(REG_B), 16'h55); poke(3'd1, 16'(REG_C), 16'h55);
        poke(3'd4, 16'h0, 16'h0);
        start = 1'b1; op_pop = 1'b1; pair = COPY_WZ_TO_BC;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mem_re !== 1'b1 || write_r !== 1'b1) begin
            n_fail++; $display("FAIL midrst_in_pop_hi: got re=%0h wr=%0h want 1 1", mem_re, write_r); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0h want 0", busy); end
        n_cmp++; if (write_r !== 1'b0) begin n_fail++; $display("FAIL midrst_write_r: got %0h want 0", write_r); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rf[REG_W] !== 8'h00) begin n_fail++; $display("FAIL midrst_w: got %h want 00", rf[REG_W]); end
        n_cmp++; if ({rf[REG_B], rf[REG_C]} !== 16'h5555) begin
            n_fail++; $display("FAIL midrst_bc: got %h want 5555", {rf[REG_B], rf[REG_C]}); end
        n_cmp++; if (copy_cnt !== 0) begin n_fail++; $display("FAIL midrst_copy: got %0d want 0", copy_cnt); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; op_pop = 1'b0; pair = COPY_NONE;
        ld_kind = 3'd0; ld_addr = 16'h0; ld_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_push;
        test_pop;
        test_wrap;
        test_pop_af;
        test_bad_pair;
        test_busy_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
